// File: rtl/mmu_alloc_client_arbiter_pkg.sv
// Shared widths and defaults for the MMU alloc client arbiter.
// Mirrors the mmu_param.vh values the arbiter depends on.
package mmu_alloc_client_arbiter_pkg;

    localparam int REQ_ID_WIDTH        = 6;
    localparam int REQ_SIZE_TYPE_WIDTH = 2;
    localparam int ALL_PAGE_IDX_WIDTH  = 10;
    localparam int FAIL_REASON_WIDTH   = 2;

    localparam int NUM_CLIENTS_DEFAULT     = 4;
    localparam int CLIENT_ID_WIDTH_DEFAULT = 2;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;
    localparam int CNT_WIDTH_DEFAULT       = 3;

endpackage

// File: rtl/mmu_alloc_client_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i upward, wrapping,
// and returns the first requester as a one-hot grant plus its index.
module mmu_alloc_client_arbiter_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mmu_alloc_client_arbiter.sv
// Shares the MMU alloc request FIFO between clients, routes responses back,
// and tracks per-client outstanding requests for limiting and quiesce.
module mmu_alloc_client_arbiter
    import mmu_alloc_client_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS     = NUM_CLIENTS_DEFAULT,
    parameter int CLIENT_ID_WIDTH = CLIENT_ID_WIDTH_DEFAULT,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
    localparam int LID_W          = REQ_ID_WIDTH - CLIENT_ID_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_CLIENTS-1:0]                     cli_alloc_valid,
    input  logic [NUM_CLIENTS*LID_W-1:0]               cli_alloc_local_id,
    input  logic [NUM_CLIENTS*REQ_SIZE_TYPE_WIDTH-1:0] cli_alloc_page_count,
    output logic [NUM_CLIENTS-1:0]                     cli_alloc_ready,
    output logic                                       alloc_req_push,
    output logic [REQ_ID_WIDTH-1:0]                    alloc_req_id,
    output logic [REQ_SIZE_TYPE_WIDTH-1:0]             alloc_req_page_count,
    input  logic                                       alloc_fifo_almost_full,
    input  logic                                       alloc_rsp_fifo_empty,
    output logic                                       alloc_rsp_pop,
    input  logic [REQ_ID_WIDTH-1:0]                    alloc_rsp_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0]              alloc_rsp_page_idx,
    input  logic                                       alloc_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]               alloc_rsp_fail_reason,
    output logic [NUM_CLIENTS-1:0]                     cli_rsp_valid,
    output logic [LID_W-1:0]                           cli_rsp_local_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0]              cli_rsp_page_idx,
    output logic                                       cli_rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]               cli_rsp_fail_reason,
    input  logic                                       quiesce,
    output logic                                       quiesce_done,
    output logic                                       busy,
    output logic                                       err_underflow
);

    logic [NUM_CLIENTS-1:0]     eligible;
    logic [NUM_CLIENTS-1:0]     req_masked;
    logic [NUM_CLIENTS-1:0]     gnt;
    logic [CLIENT_ID_WIDTH-1:0] gnt_idx;
    logic                       gnt_any;
    logic                       grant_en;

    logic [CLIENT_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]       cnt_q [NUM_CLIENTS];
    logic [CNT_WIDTH-1:0]       cnt_d [NUM_CLIENTS];
    logic                       err_q, err_d;
    logic                       busy_c;

    logic                           push_q;
    logic [REQ_ID_WIDTH-1:0]        req_id_q;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] req_pc_q;

    logic [CLIENT_ID_WIDTH-1:0]    rsp_cid;
    logic                          rsp_cid_ok;
    logic [NUM_CLIENTS-1:0]        rsp_valid_q, rsp_valid_d;
    logic [LID_W-1:0]              rsp_lid_q;
    logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_q;
    logic                          rsp_fail_q;
    logic [FAIL_REASON_WIDTH-1:0]  rsp_reason_q;

    // The almost-full threshold already reserves the slot for next cycle's push.
    assign grant_en = !alloc_fifo_almost_full && !quiesce;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            eligible[i] = cli_alloc_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
        req_masked = grant_en ? eligible : '0;
    end

    mmu_alloc_client_arbiter_rr_arbiter #(
        .N     (NUM_CLIENTS),
        .IDX_W (CLIENT_ID_WIDTH)
    ) u_rr (
        .req_i (req_masked),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign cli_alloc_ready = gnt;
    assign ptr_d = !gnt_any ? ptr_q :
                   (gnt_idx == CLIENT_ID_WIDTH'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;

    assign alloc_rsp_pop = !alloc_rsp_fifo_empty;
    assign rsp_cid       = alloc_rsp_id[REQ_ID_WIDTH-1 -: CLIENT_ID_WIDTH];
    assign rsp_cid_ok    = 32'(rsp_cid) < 32'(NUM_CLIENTS);

    always_comb begin
        rsp_valid_d = '0;
        if (alloc_rsp_pop && rsp_cid_ok) rsp_valid_d[rsp_cid] = 1'b1;
    end

    // A response with nothing outstanding for its client (or an unknown client)
    // means tracking was lost, e.g. across a reset; flag it and clamp at zero.
    always_comb begin
        err_d  = err_q;
        busy_c = 1'b0;
        if (alloc_rsp_pop && !rsp_cid_ok) err_d = 1'b1;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cnt_d[i] = cnt_q[i];
            busy_c   = busy_c | (cnt_q[i] != '0);
            if (alloc_rsp_pop && rsp_cid_ok && rsp_cid == CLIENT_ID_WIDTH'(i)) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                if (!gnt[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end else if (gnt[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            err_q        <= 1'b0;
            push_q       <= 1'b0;
            req_id_q     <= '0;
            req_pc_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_lid_q    <= '0;
            rsp_page_q   <= '0;
            rsp_fail_q   <= 1'b0;
            rsp_reason_q <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            push_q      <= gnt_any;
            rsp_valid_q <= rsp_valid_d;
            for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
            if (gnt_any) begin
                req_id_q <= {gnt_idx, cli_alloc_local_id[gnt_idx*LID_W +: LID_W]};
                req_pc_q <= cli_alloc_page_count[gnt_idx*REQ_SIZE_TYPE_WIDTH +: REQ_SIZE_TYPE_WIDTH];
            end
            if (alloc_rsp_pop) begin
                rsp_lid_q    <= alloc_rsp_id[LID_W-1:0];
                rsp_page_q   <= alloc_rsp_page_idx;
                rsp_fail_q   <= alloc_rsp_fail;
                rsp_reason_q <= alloc_rsp_fail_reason;
            end
        end
    end

    assign alloc_req_push       = push_q;
    assign alloc_req_id         = req_id_q;
    assign alloc_req_page_count = req_pc_q;
    assign cli_rsp_valid        = rsp_valid_q;
    assign cli_rsp_local_id     = rsp_lid_q;
    assign cli_rsp_page_idx     = rsp_page_q;
    assign cli_rsp_fail         = rsp_fail_q;
    assign cli_rsp_fail_reason  = rsp_reason_q;
    assign busy                 = busy_c;
    assign quiesce_done         = quiesce && !busy_c && !push_q;
    assign err_underflow        = err_q;

endmodule
